// File: rtl/snn_multilayer_engine.sv
// snn_multilayer_engine
// Two-layer spiking inference engine.
//   Layer 1: for each of the N_IN latched channels, s = hi nibble + lo nibble.
//            The channel fires when s > TH1.
//   Layer 2: for each output o and each firing channel i, the engine fetches
//            weight w(o,i) from address o*N_IN+i. It then adds s_i shifted by
//            the signed 4-bit amount w_data[3:0] into acc[o].
//   Argmax:  picks the largest accumulator (ties go to the lowest index).
//            spikes[o] is set when acc[o] is non-zero.
// Optional build macro SNN_SAT_ACC_EN: left shifts and accumulations saturate
// at 2^ACC_W-1 instead of wrapping.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle start pulse, accepted only when idle
//   in_vec              N_IN channels of DW bits, channel i at [i*DW +: DW]
//   w_req/w_addr        one-cycle weight read request and its address
//   w_valid/w_data      weight response; only honoured while waiting for it
//   busy                run in progress
//   prediction, spikes  result of the last completed run
//   err_timeout         sticky: a weight fetch timed out during this run
//   done                one-cycle completion pulse
module snn_multilayer_engine #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int DW      = 8,
  parameter int ADDR_W  = 6,
  parameter int ACC_W   = 12,
  parameter int TH1     = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_IN*DW-1:0]       in_vec,
  output logic                     w_req,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic                     w_valid,
  input  logic [DW-1:0]            w_data,
  output logic                     busy,
  output logic [$clog2(N_OUT)-1:0] prediction,
  output logic [N_OUT-1:0]         spikes,
  output logic                     err_timeout,
  output logic                     done
);

  localparam int PW = $clog2(N_OUT);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW = DW / 2 + 1;
  localparam int WW = ACC_W + SW + 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_L1, S_REQ, S_WAIT, S_ARGMAX} state_t;

  state_t              state_reg;
  logic [N_IN*DW-1:0]  vec_reg;
  logic [PW-1:0]       o_reg;
  logic [IW-1:0]       i_reg;
  logic [PW-1:0]       j_reg;
  logic [CW-1:0]       cnt_reg;
  logic [ACC_W-1:0]    best_val_reg;
  logic [PW-1:0]       best_idx_reg;

  logic [SW-1:0]       s_comb [N_IN];
  logic [N_IN-1:0]     fire_comb;
  logic [ACC_W-1:0]    acc_vec [N_OUT];
  logic [N_OUT-1:0]    spike_comb;

  // Only the low nibble of a weight word carries the shift amount.
  logic                w_data_unused;
  assign w_data_unused = ^w_data[DW-1:4];

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PW-1:0] o, input logic [IW-1:0] i);
    return ADDR_W'(int'(o) * N_IN + int'(i));
  endfunction

  // Positive w shifts left, negative w shifts right (logical) by -w.
  function automatic logic [ACC_W-1:0] shift_by_signed(input logic [SW-1:0] s, input logic [3:0] w);
    logic [WW-1:0]    wide;
    logic [3:0]       mag;
    logic [ACC_W-1:0] res;
    wide = WW'(s);
    if (w[3]) begin
      mag = 4'(~w + 4'd1);
      res = ACC_W'(wide >> mag);
    end else begin
      wide = wide << w[2:0];
`ifdef SNN_SAT_ACC_EN
      res = (|(wide >> ACC_W)) ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
      res = wide[ACC_W-1:0];
`endif
    end
    return res;
  endfunction

  // Layer 1: nibble sums and threshold spikes from the latched vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_l1
      logic [DW/2-1:0] lo;
      logic [DW/2-1:0] hi;
      assign lo = vec_reg[gi*DW +: DW/2];
      assign hi = vec_reg[gi*DW+DW/2 +: DW/2];
      assign s_comb[gi] = SW'(lo) + SW'(hi);
      assign fire_comb[gi] = int'(s_comb[gi]) > TH1;
    end
  endgenerate

  // Find the first firing channel, and the next firing channel after i_reg.
  logic          any_fire;
  logic [IW-1:0] first_fire;
  logic [IW-1:0] next_fire;
  logic          has_next;
  always_comb begin
    any_fire   = |fire_comb;
    first_fire = '0;
    next_fire  = '0;
    has_next   = 1'b0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (fire_comb[k]) begin
        first_fire = IW'(k);
      end
      if (fire_comb[k] && (k > int'(i_reg))) begin
        next_fire = IW'(k);
        has_next  = 1'b1;
      end
    end
  end

  // Operand selection for the accumulate and argmax datapaths.
  logic [SW-1:0]    s_sel;
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] acc_sel;
  always_comb begin
    s_sel   = '0;
    acc_cur = '0;
    acc_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (i_reg == IW'(k)) s_sel = s_comb[k];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (o_reg == PW'(k)) acc_cur = acc_vec[k];
      if (j_reg == PW'(k)) acc_sel = acc_vec[k];
    end
  end

  // A timed-out fetch is handled as weight 0, so s_i is still added unshifted.
  logic             timeout_hit;
  logic             acc_we;
  logic [3:0]       w_eff;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_sum;
  assign timeout_hit = (state_reg == S_WAIT) && !w_valid && (cnt_reg == CW'(TIMEOUT - 1));
  assign acc_we      = (state_reg == S_WAIT) && (w_valid || timeout_hit);
  assign w_eff       = w_valid ? w_data[3:0] : 4'd0;
  assign acc_add     = shift_by_signed(s_sel, w_eff);

`ifdef SNN_SAT_ACC_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, acc_cur} + {1'b0, acc_add};
  assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_sum  = acc_cur + acc_add;
`endif

  // Layer-2 accumulators, one register per output neuron.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_acc
      logic [ACC_W-1:0] acc_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
          acc_reg <= '0;
        end else if (acc_we && o_reg == PW'(gi)) begin
          acc_reg <= acc_sum;
        end
      end
      assign acc_vec[gi]    = acc_reg;
      assign spike_comb[gi] = |acc_reg;
    end
  endgenerate

  // Argmax step: a strict greater-than keeps the earliest index on ties.
  logic             take_new;
  logic [ACC_W-1:0] cand_val;
  logic [PW-1:0]    cand_idx;
  assign take_new = (j_reg == '0) || (acc_sel > best_val_reg);
  assign cand_val = take_new ? acc_sel : best_val_reg;
  assign cand_idx = take_new ? j_reg : best_idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      vec_reg      <= '0;
      o_reg        <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      cnt_reg      <= '0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
      w_req        <= 1'b0;
      w_addr       <= '0;
      busy         <= 1'b0;
      prediction   <= '0;
      spikes       <= '0;
      err_timeout  <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            vec_reg     <= in_vec;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            o_reg       <= '0;
            i_reg       <= '0;
            state_reg   <= S_L1;
          end
        end
        S_L1: begin
          if (any_fire) begin
            o_reg     <= '0;
            i_reg     <= first_fire;
            w_addr    <= addr_of('0, first_fire);
            w_req     <= 1'b1;
            state_reg <= S_REQ;
          end else begin
            j_reg     <= '0;
            state_reg <= S_ARGMAX;
          end
        end
        S_REQ: begin
          w_req     <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_we) begin
            if (timeout_hit) err_timeout <= 1'b1;
            if (has_next) begin
              i_reg     <= next_fire;
              w_addr    <= addr_of(o_reg, next_fire);
              w_req     <= 1'b1;
              state_reg <= S_REQ;
            end else if (o_reg == PW'(N_OUT - 1)) begin
              j_reg     <= '0;
              state_reg <= S_ARGMAX;
            end else begin
              o_reg     <= o_reg + 1'b1;
              i_reg     <= first_fire;
              w_addr    <= addr_of(o_reg + 1'b1, first_fire);
              w_req     <= 1'b1;
              state_reg <= S_REQ;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_ARGMAX: begin
          best_val_reg <= cand_val;
          best_idx_reg <= cand_idx;
          if (j_reg == PW'(N_OUT - 1)) begin
            prediction <= cand_idx;
            spikes     <= spike_comb;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= S_IDLE;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_multilayer_engine.sv
// Directed bench for snn_multilayer_engine: a table of run vectors with
// hand-computed results, plus sequences for start-while-busy, mid-run reset
// and accumulator overflow (wrap or saturate, depending on SNN_SAT_ACC_EN).
module tb_snn_multilayer_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in_vec;
  logic        w_req;
  logic [5:0]  w_addr;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        busy;
  logic [1:0]  prediction;
  logic [3:0]  spikes;
  logic        err_timeout;
  logic        done;

  // Second instance: narrow accumulators for the overflow case.
  logic        start2;
  logic [15:0] in_vec2;
  logic        w_req2;
  logic [5:0]  w_addr2;
  logic        w_valid2;
  logic [7:0]  w_data2;
  logic        busy2;
  logic [0:0]  prediction2;
  logic [1:0]  spikes2;
  logic        err2;
  logic        done2;

  snn_multilayer_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
    .busy(busy), .prediction(prediction), .spikes(spikes),
    .err_timeout(err_timeout), .done(done)
  );

  snn_multilayer_engine #(.N_IN(2), .N_OUT(2), .ACC_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_vec(in_vec2),
    .w_req(w_req2), .w_addr(w_addr2), .w_valid(w_valid2), .w_data(w_data2),
    .busy(busy2), .prediction(prediction2), .spikes(spikes2),
    .err_timeout(err2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Weight memory model: answers one cycle after each request unless the
  // request index equals drop_at (used to force a timeout).
  logic [7:0] mem [64];
  logic [5:0] req_log [256];
  int         req_count = 0;
  int         drop_at = -1;
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic       pend2 = 1'b0;
  logic [7:0] pend_data2 = 8'h00;

  initial begin
    w_valid = 1'b0;
    w_data  = 8'h00;
    w_valid2 = 1'b0;
    w_data2  = 8'h00;
  end

  always @(negedge clk) begin
    w_valid = pend;
    w_data  = pend_data;
    pend    = 1'b0;
    if (w_req) begin
      req_log[req_count % 256] = w_addr;
      pend      = (req_count != drop_at);
      pend_data = mem[w_addr];
      req_count++;
    end
    w_valid2 = pend2;
    w_data2  = pend_data2;
    pend2    = w_req2;
    if (w_req2) begin
      pend_data2 = (w_addr2 == 6'd0) ? 8'h07 : (w_addr2 == 6'd2) ? 8'h04 : 8'h00;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [31:0]     in_vec;
    logic [15:0][7:0] wts;
    bit              drop;
    int              exp_lat;
    int              exp_nreq;
    logic [3:0][5:0] exp_addr;
    logic [1:0]      exp_pred;
    logic [3:0]      exp_spikes;
    logic            exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int k, input string nm, input logic [31:0] iv, input bit drp,
                         input int lat, input int nreq, input logic [3:0][5:0] addrs,
                         input logic [1:0] pred, input logic [3:0] spk, input logic err);
    vecs[k].name       = nm;
    vecs[k].in_vec     = iv;
    vecs[k].wts        = '0;
    vecs[k].drop       = drp;
    vecs[k].exp_lat    = lat;
    vecs[k].exp_nreq   = nreq;
    vecs[k].exp_addr   = addrs;
    vecs[k].exp_pred   = pred;
    vecs[k].exp_spikes = spk;
    vecs[k].exp_err    = err;
  endtask

  // One full run. Latency n = edges from the start-sampling edge up to and
  // including the edge that raises done. restart_at > 0 pulses start again
  // (with a zeroed vector) while the run is busy.
  task automatic run_vec(input vec_t v, input int restart_at);
    int n;
    int base;
    int nreq;
    int na;
    for (int a = 0; a < 64; a++) mem[a] = (a < 16) ? v.wts[a] : 8'h00;
    base    = req_count;
    drop_at = v.drop ? req_count : -1;
    @(negedge clk);
    in_vec = v.in_vec;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({v.name, " busy"}, busy, 1);
    while (!done && n < 200) begin
      start = (n == restart_at);
      if (start) in_vec = '0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({v.name, " done seen"}, done, 1);
    check({v.name, " latency"}, n, v.exp_lat);
    check({v.name, " prediction"}, prediction, v.exp_pred);
    check({v.name, " spikes"}, spikes, v.exp_spikes);
    check({v.name, " err_timeout"}, err_timeout, v.exp_err);
    nreq = req_count - base;
    check({v.name, " requests"}, nreq, v.exp_nreq);
    na = (v.exp_nreq < 4) ? v.exp_nreq : 4;
    for (int j = 0; j < na; j++) begin
      check({v.name, $sformatf(" addr%0d", j)}, req_log[(base + j) % 256], v.exp_addr[j]);
    end
    @(negedge clk);
    check({v.name, " done pulse width"}, done, 0);
    check({v.name, " idle busy"}, busy, 0);
    $display("run %s: latency=%0d requests=%0d prediction=%0d spikes=%b err=%0b",
             v.name, n, nreq, prediction, spikes, err_timeout);
  endtask

  int n2;
  int dcount;
  logic [0:0] exp_pred2;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    in_vec  = '0;
    start2  = 1'b0;
    in_vec2 = '0;
    for (int a = 0; a < 64; a++) mem[a] = 8'h00;

    set_vec(0, "zero", 32'h0000_0000, 1'b0, 6, 0, '0, 2'd0, 4'b0000, 1'b0);
    set_vec(1, "ch2", 32'h0021_0000, 1'b0, 14, 4, {6'd14, 6'd10, 6'd6, 6'd2}, 2'd1, 4'b1111, 1'b0);
    vecs[1].wts[6] = 8'h02;
    set_vec(2, "neg", 32'h0000_0088, 1'b0, 14, 4, {6'd12, 6'd8, 6'd4, 6'd0}, 2'd3, 4'b1110, 1'b0);
    vecs[2].wts[0]  = 8'h08;
    vecs[2].wts[12] = 8'h01;
    set_vec(3, "tie", 32'h0000_0011, 1'b0, 14, 4, {6'd12, 6'd8, 6'd4, 6'd0}, 2'd1, 4'b1111, 1'b0);
    vecs[3].wts[4]  = 8'h02;
    vecs[3].wts[8]  = 8'h02;
    vecs[3].wts[12] = 8'h01;
    set_vec(4, "timeout", 32'h0000_0011, 1'b1, 28, 4, {6'd12, 6'd8, 6'd4, 6'd0}, 2'd1, 4'b1111, 1'b1);
    vecs[4].wts[0]  = 8'h03;
    vecs[4].wts[4]  = 8'h01;
    vecs[4].wts[8]  = 8'h01;
    vecs[4].wts[12] = 8'h01;
    set_vec(5, "twoch", 32'h0000_3002, 1'b0, 22, 8, {6'd5, 6'd4, 6'd1, 6'd0}, 2'd1, 4'b0111, 1'b0);
    vecs[5].wts[0]  = 8'h01;
    vecs[5].wts[1]  = 8'hF0;
    vecs[5].wts[4]  = 8'h0F;
    vecs[5].wts[5]  = 8'h02;
    vecs[5].wts[9]  = 8'h0E;
    vecs[5].wts[12] = 8'h0E;
    vecs[5].wts[13] = 8'h0E;

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset w_req", w_req, 0);
    check("reset prediction", prediction, 0);
    check("reset spikes", spikes, 0);
    check("reset err_timeout", err_timeout, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], -1);

    // Reset mid-fetch, after a timeout has already set err_timeout.
    for (int a = 0; a < 64; a++) mem[a] = (a < 16) ? vecs[4].wts[a] : 8'h00;
    drop_at = req_count;
    @(negedge clk);
    in_vec = vecs[4].in_vec;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("midrun busy", busy, 1);
    check("midrun err_timeout", err_timeout, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort w_req", w_req, 0);
    check("abort w_addr", w_addr, 0);
    check("abort prediction", prediction, 0);
    check("abort spikes", spikes, 0);
    check("abort err_timeout", err_timeout, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort no done", dcount, 0);
    $display("run abort: done pulses after reset=%0d", dcount);

    // Fresh run after the abort, then a run with start pulsed while busy.
    run_vec(vecs[1], -1);
    run_vec(vecs[1], 3);

    // Overflow on the narrow instance: s=15, w=+7 on o=0 (1920), w=+4 on o=1 (240).
`ifdef SNN_SAT_ACC_EN
    exp_pred2 = 1'b0;
`else
    exp_pred2 = 1'b1;
`endif
    @(negedge clk);
    in_vec2 = 16'h00F0;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n2 = 1;
    while (!done2 && n2 < 100) begin
      @(negedge clk);
      n2++;
    end
    check("ovf done seen", done2, 1);
    check("ovf latency", n2, 8);
    check("ovf prediction", prediction2, exp_pred2);
    check("ovf spikes", spikes2, 2'b11);
    check("ovf err_timeout", err2, 0);
    $display("run ovf: latency=%0d prediction=%0d spikes=%b", n2, prediction2, spikes2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
